// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges an ALU result and a buffered mem/mul result into the regfile write port.
// Optional WB_BYPASS_EN adds a write-to-read forwarding path for two read ports.
module wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_val,
  output logic              alu_stall,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_val,
  output logic              writeEn,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] writeVal,
  output logic [31:0]       busy_mask
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_src1,
  input  logic [ADDR_W-1:0] byp_src2,
  input  logic [DATA_W-1:0] rf_reg1,
  input  logic [DATA_W-1:0] rf_reg2,
  output logic [DATA_W-1:0] byp_reg1,
  output logic [DATA_W-1:0] byp_reg2
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [ADDR_W-1:0] fdest_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fdest_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fval_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] fval_d  [FIFO_DEPTH];

  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] val_q, val_d;

  logic [AW-1:0]     wr_idx, rd_idx;
  logic [PW-1:0]     count;
  logic              empty, full;
  logic              push, pop;

  assign wr_idx = wr_q[AW-1:0];
  assign rd_idx = rd_q[AW-1:0];
  assign count  = wr_q - rd_q;
  assign empty  = (wr_q == rd_q);
  // Same index with differing wrap bits means the writer lapped the reader.
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);

  assign mem_ready = !full && !rst;
  assign push      = mem_valid && mem_ready;
  assign pop       = !alu_valid && !empty;

  assign alu_stall = !rst && (cnt_q == LIMIT);

  assign writeEn  = we_q;
  assign dest     = dest_q;
  assign writeVal = val_q;

  always_comb begin
    fdest_d = fdest_q;
    fval_d  = fval_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push) begin
      fdest_d[wr_idx] = mem_dest;
      fval_d[wr_idx]  = mem_val;
      wr_d            = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
  end

  always_comb begin
    we_d   = 1'b0;
    dest_d = dest_q;
    val_d  = val_q;
    unique case (1'b1)
      alu_valid: begin
        we_d   = (alu_dest != '0);
        dest_d = alu_dest;
        val_d  = alu_val;
      end
      pop: begin
        we_d   = (fdest_q[rd_idx] != '0);
        dest_d = fdest_q[rd_idx];
        val_d  = fval_q[rd_idx];
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Saturating: an ALU that ignores the stall leaves the count parked at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (empty || pop) begin
      cnt_d = 4'd0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      dest_q <= '0;
      val_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      val_q  <= val_d;
    end
  end

  always_ff @(posedge clk) begin
    fdest_q <= fdest_d;
    fval_q  <= fval_d;
  end

  function automatic logic [31:0] onehot(
    input logic [ADDR_W-1:0] a
  );
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) begin
      if (a == ADDR_W'(r)) m[r] = 1'b1;
    end
    return m;
  endfunction

  logic [AW-1:0] off;

  always_comb begin
    busy_mask = '0;
    off       = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = AW'(i) - rd_idx;
      if ({1'b0, off} < count) begin
        busy_mask = busy_mask | onehot(fdest_q[i]);
      end
    end
    if (we_q) begin
      busy_mask = busy_mask | onehot(dest_q);
    end
    busy_mask[0] = 1'b0;
    if (rst) begin
      busy_mask = '0;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_reg1 =
    (we_q && dest_q == byp_src1 && byp_src1 != '0)
    ? val_q : rf_reg1;
  assign byp_reg2 =
    (we_q && dest_q == byp_src2 && byp_src2 != '0)
    ? val_q : rf_reg2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, FIFO fill/order,
// starvation stall, r0 suppression, back-to-back and optional bypass.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_dest = '0;
  logic [31:0] alu_val = '0;
  logic        alu_stall;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_dest = '0;
  logic [31:0] mem_val = '0;
  logic        writeEn;
  logic [4:0]  dest;
  logic [31:0] writeVal;
  logic [31:0] busy_mask;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_src1 = '0;
  logic [4:0]  byp_src2 = '0;
  logic [31:0] rf_reg1 = '0;
  logic [31:0] rf_reg2 = '0;
  logic [31:0] byp_reg1;
  logic [31:0] byp_reg2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_dest  (alu_dest),
    .alu_val   (alu_val),
    .alu_stall (alu_stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dest  (mem_dest),
    .mem_val   (mem_val),
    .writeEn   (writeEn),
    .dest      (dest),
    .writeVal  (writeVal),
    .busy_mask (busy_mask)
`ifdef WB_BYPASS_EN
    ,
    .byp_src1  (byp_src1),
    .byp_src2  (byp_src2),
    .rf_reg1   (rf_reg1),
    .rf_reg2   (rf_reg2),
    .byp_reg1  (byp_reg1),
    .byp_reg2  (byp_reg2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({writeEn, dest, writeVal} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outregs got=%h exp=0",
               {writeEn, dest, writeVal});
    end
    total++;
    if ({mem_ready, alu_stall, busy_mask} !== 34'd0) begin
      bad++;
      $display("FAIL reset_comb got=%h exp=0",
               {mem_ready, alu_stall, busy_mask});
    end
    rst = 1'b0;
    #1;
    total++;
    if (mem_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", mem_ready);
    end
  endtask

  task automatic test_mid_reset();
    alu_valid = 1'b1;
    alu_dest  = 5'd1;
    alu_val   = 32'h10;
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_dest = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd6;
      mem_val  = 32'(i);
      tick();
    end
    mem_valid = 1'b0;
    total++;
    if (busy_mask !== 32'h5A) begin
      bad++;
      $display("FAIL mid_reset_busy got=%h exp=0000005a", busy_mask);
    end
    alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({mem_ready, alu_stall, busy_mask} !== 34'd0) begin
      bad++;
      $display("FAIL mid_reset_during got=%h exp=0",
               {mem_ready, alu_stall, busy_mask});
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({mem_ready, writeEn, busy_mask} !== {1'b1, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL mid_reset_after got=%h exp=200000000",
               {mem_ready, writeEn, busy_mask});
    end
    alu_valid = 1'b1;
    alu_dest  = 5'd5;
    alu_val   = 32'h11;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({writeEn, dest, writeVal} !== {1'b1, 5'd5, 32'h11}) begin
      bad++;
      $display("FAIL mid_reset_alu got=%h exp=%h",
               {writeEn, dest, writeVal}, {1'b1, 5'd5, 32'h11});
    end
    tick();
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL mid_reset_discard got=%h exp=0",
               {writeEn, busy_mask});
    end
  endtask

  task automatic test_mem_latency();
    mem_valid = 1'b1;
    mem_dest  = 5'd7;
    mem_val   = 32'hA5A5;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({writeEn, busy_mask} !== {1'b0, 32'h80}) begin
      bad++;
      $display("FAIL mem_lat_n1 got=%h exp=%h",
               {writeEn, busy_mask}, {1'b0, 32'h80});
    end
    tick();
    total++;
    if ({writeEn, dest, writeVal, busy_mask} !==
        {1'b1, 5'd7, 32'hA5A5, 32'h80}) begin
      bad++;
      $display("FAIL mem_lat_n2 got=%h exp=%h",
               {writeEn, dest, writeVal, busy_mask},
               {1'b1, 5'd7, 32'hA5A5, 32'h80});
    end
    tick();
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL mem_lat_done got=%h exp=0", {writeEn, busy_mask});
    end
  endtask

  task automatic test_fill_order();
    alu_valid = 1'b1;
    alu_dest  = 5'd2;
    alu_val   = 32'h100;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_ready_%0d got=%b exp=1", i, mem_ready);
      end
      mem_valid = 1'b1;
      mem_dest  = 5'(10 + i);
      mem_val   = 32'hA0 + 32'(i);
      tick();
    end
    mem_valid = 1'b0;
    total++;
    if ({mem_ready, alu_stall, busy_mask} !==
        {1'b0, 1'b1, 32'h3C04}) begin
      bad++;
      $display("FAIL fill_full got=%h exp=%h",
               {mem_ready, alu_stall, busy_mask},
               {1'b0, 1'b1, 32'h3C04});
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({writeEn, dest, writeVal} !==
          {1'b1, 5'(10 + i), 32'hA0 + 32'(i)}) begin
        bad++;
        $display("FAIL fill_order_%0d got=%h exp=%h", i,
                 {writeEn, dest, writeVal},
                 {1'b1, 5'(10 + i), 32'hA0 + 32'(i)});
      end
      if (i == 0) begin
        total++;
        if ({mem_ready, alu_stall} !== 2'b10) begin
          bad++;
          $display("FAIL fill_release got=%b exp=10",
                   {mem_ready, alu_stall});
        end
      end
    end
    tick();
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL fill_drain got=%h exp=0", {writeEn, busy_mask});
    end
  endtask

  task automatic test_starve();
    alu_valid = 1'b1;
    alu_dest  = 5'd8;
    alu_val   = 32'h80;
    mem_valid = 1'b1;
    mem_dest  = 5'd20;
    mem_val   = 32'h55;
    tick();
    mem_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (alu_stall !== (k == 3)) begin
        bad++;
        $display("FAIL starve_cnt_%0d got=%b exp=%b",
                 k, alu_stall, (k == 3));
      end
      if (k < 3) tick();
    end
    tick();
    total++;
    if ({alu_stall, writeEn, dest} !== {1'b1, 1'b1, 5'd8}) begin
      bad++;
      $display("FAIL starve_violate got=%h exp=%h",
               {alu_stall, writeEn, dest}, {1'b1, 1'b1, 5'd8});
    end
    alu_valid = 1'b0;
    tick();
    total++;
    if ({alu_stall, writeEn, dest, writeVal} !==
        {1'b0, 1'b1, 5'd20, 32'h55}) begin
      bad++;
      $display("FAIL starve_pop got=%h exp=%h",
               {alu_stall, writeEn, dest, writeVal},
               {1'b0, 1'b1, 5'd20, 32'h55});
    end
    alu_valid = 1'b1;
    alu_dest  = 5'd9;
    alu_val   = 32'h99;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({writeEn, dest, writeVal} !== {1'b1, 5'd9, 32'h99}) begin
      bad++;
      $display("FAIL starve_resume got=%h exp=%h",
               {writeEn, dest, writeVal}, {1'b1, 5'd9, 32'h99});
    end
    tick();
  endtask

  task automatic test_r0();
    alu_valid = 1'b1;
    alu_dest  = 5'd0;
    alu_val   = 32'hFF;
    mem_valid = 1'b1;
    mem_dest  = 5'd0;
    mem_val   = 32'hEE;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL r0_alu got=%h exp=0", {writeEn, busy_mask});
    end
    tick();
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL r0_mem got=%h exp=0", {writeEn, busy_mask});
    end
    mem_valid = 1'b1;
    mem_dest  = 5'd4;
    mem_val   = 32'h44;
    tick();
    mem_valid = 1'b0;
    tick();
    total++;
    if ({writeEn, dest, writeVal} !== {1'b1, 5'd4, 32'h44}) begin
      bad++;
      $display("FAIL r0_drained got=%h exp=%h",
               {writeEn, dest, writeVal}, {1'b1, 5'd4, 32'h44});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_dest = 5'(16 + i);
      mem_val  = 32'hB0 + 32'(i);
      tick();
      if (i > 0) begin
        total++;
        if ({mem_ready, writeEn, dest, writeVal} !==
            {1'b1, 1'b1, 5'(15 + i), 32'hAF + 32'(i)}) begin
          bad++;
          $display("FAIL b2b_%0d got=%h exp=%h", i,
                   {mem_ready, writeEn, dest, writeVal},
                   {1'b1, 1'b1, 5'(15 + i), 32'hAF + 32'(i)});
        end
      end
    end
    mem_valid = 1'b0;
    tick();
    total++;
    if ({writeEn, dest, writeVal} !== {1'b1, 5'd18, 32'hB2}) begin
      bad++;
      $display("FAIL b2b_last got=%h exp=%h",
               {writeEn, dest, writeVal}, {1'b1, 5'd18, 32'hB2});
    end
    tick();
    total++;
    if ({writeEn, busy_mask} !== 33'd0) begin
      bad++;
      $display("FAIL b2b_idle got=%h exp=0", {writeEn, busy_mask});
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1'b1;
    alu_dest  = 5'd9;
    alu_val   = 32'h1234;
    tick();
    alu_valid = 1'b0;
    byp_src1 = 5'd9;
    rf_reg1  = 32'd0;
    byp_src2 = 5'd3;
    rf_reg2  = 32'h66;
    #1;
    total++;
    if ({byp_reg1, byp_reg2} !== {32'h1234, 32'h66}) begin
      bad++;
      $display("FAIL bypass_hit got=%h exp=%h",
               {byp_reg1, byp_reg2}, {32'h1234, 32'h66});
    end
    byp_src1 = 5'd0;
    rf_reg1  = 32'h77;
    byp_src2 = 5'd9;
    #1;
    total++;
    if ({byp_reg1, byp_reg2} !== {32'h77, 32'h1234}) begin
      bad++;
      $display("FAIL bypass_r0 got=%h exp=%h",
               {byp_reg1, byp_reg2}, {32'h77, 32'h1234});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_mid_reset();
    test_mem_latency();
    test_fill_order();
    test_starve();
    test_r0();
    test_back_to_back();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that sits directly upstream of the register file write port (`dest`, `writeVal`, `writeEn`). It merges two result sources into the single port:
- a fixed-latency ALU path, which cannot stall;
- a variable-latency memory/multiply path with a valid/ready handshake and a small FIFO.

It also exports a pending-destination mask so decode can detect hazards.

## Interface
Parameters:
- `DATA_W`, 32, result width
- `ADDR_W`, 5, register address width (32 registers)
- `FIFO_DEPTH`, 4, memory-path buffer entries, power of 2, ≥2
- `STARVE_LIMIT`, 3, consecutive non-popped cycles before ALU is stalled; range 1–15

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_dest` in ADDR_W: ALU destination register.
- `alu_val` in DATA_W: ALU result.
- `alu_stall` out 1: ALU must hold (not assert `alu_valid`) this cycle.
- `mem_valid` in 1: memory-path result offered.
- `mem_ready` out 1: FIFO can accept.
- `mem_dest` in ADDR_W: memory-path destination.
- `mem_val` in DATA_W: memory-path result.
- `writeEn` out 1: register file write strobe, registered.
- `dest` out ADDR_W: register file write address, registered.
- `writeVal` out DATA_W: register file write data, registered.
- `busy_mask` out 32: bit r set while a write to register r is in the FIFO or on the output registers.

## Operation
- Memory handshake:
  - Transfer occurs when `mem_valid && mem_ready`.
  - `mem_ready = !full && !rst`.
  - There is no pass-through: every accepted result enters the FIFO.
- Arbitration, evaluated each cycle:
  - If `alu_valid`, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped and selected.
  - Otherwise nothing is selected.
- A push and a pop in the same cycle are legal whenever the FIFO is not full before the edge. Occupancy is then unchanged.
- Register 0 is never written. A selected result with destination 0 is consumed (popped or accepted) but drives `writeEn=0`.
- Starvation counter (4 bits):
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on a pop, or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
  - `alu_stall = (cnt == STARVE_LIMIT)`.
- Stall protocol:
  - While `alu_stall` is high, upstream keeps `alu_valid` low. The FIFO head therefore pops that cycle and the counter clears.
  - Protocol violation (`alu_valid` high during a stall): the ALU still wins, no data is lost, and the counter holds at its limit.
- `busy_mask` is combinational: the OR of one-hot decodes of every valid FIFO entry's destination, plus `dest` when `writeEn`. Bit 0 is always 0.
- WAW ordering between the two sources is upstream's responsibility via `busy_mask`. Within the memory path, order is FIFO order.
- Reset, including mid-operation:
  - FIFO contents are discarded and pointers cleared.
  - Counter cleared.
  - `writeEn`, `dest`, `writeVal` = 0.
  - `alu_stall` = 0, `busy_mask` = 0, `mem_ready` = 0 during reset.

## Timing
- ALU: `alu_valid` at edge N → `writeEn` high during cycle N+1, with the regfile written at edge N+2's sampling.
- Memory: accepted at cycle N → earliest `writeEn` in cycle N+2 (enqueue at N, pop at N+1).
- Throughput: one regfile write per cycle.
- Pointers are `log2(FIFO_DEPTH)+1` bits; the extra bit distinguishes full from empty across wrap-around.
- `mem_ready` falls the cycle after the push that fills the FIFO. It rises the cycle after a pop from full.

## Configuration
- `WB_BYPASS_EN` defined:
  - Adds inputs `byp_src1` and `byp_src2` (ADDR_W), and `rf_reg1` and `rf_reg2` (DATA_W).
  - Adds outputs `byp_reg1` and `byp_reg2` (DATA_W).
  - `byp_regX = (writeEn && dest == byp_srcX && byp_srcX != 0) ? writeVal : rf_regX`.
  - This hides the same-cycle read-during-write of the register file.
- `WB_BYPASS_EN` undefined: these ports and that logic are absent.

## Test plan
- Reset with 3 entries queued → next cycle `mem_ready=1`, `writeEn=0`, `busy_mask=0`. A subsequent ALU write (r5=0x11) appears 1 cycle after `alu_valid`.
- Memory write r7=0xA5A5 with ALU idle → `writeEn` with `dest=7` exactly 2 cycles after the handshake. `busy_mask[7]` is set from the cycle after acceptance until `writeEn` drops.
- Push 4 memory results while `alu_valid` is held high → `mem_ready=0` after the 4th. Order on release is preserved.
- Continuous `alu_valid` with 1 FIFO entry and `STARVE_LIMIT=3` → `alu_stall` rises on the 3rd non-popped cycle. With `alu_valid` dropped, the head pops, the stall clears the next cycle, and the ALU write resumes.
- ALU write to r0 and memory write to r0 → both consumed, `writeEn` stays 0, FIFO drains.
- With `WB_BYPASS_EN` defined: `writeEn`, `dest=9`, `writeVal=0x1234`, `byp_src1=9`, `rf_reg1=0` → `byp_reg1=0x1234`. With `byp_src1=0` → `byp_reg1=rf_reg1`.
